// File: rtl/iq_capture_dumper.sv
// One-shot I/Q snapshot recorder: captures DEPTH strobed samples into RAM, then streams them
// byte-wise to a UART TX over a start/busy handshake. Optional framing header: DUMP_HEADER_EN.
module iq_capture_dumper #(
  parameter int SW       = 8,
  parameter int NCH      = 2,
  parameter int DEPTH    = 256,
  parameter int AUTO_ARM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          smp_stb,
  input  logic [SW-1:0] smp_i,
  input  logic [SW-1:0] smp_q,
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    tx_dat,
  output logic          capturing,
  output logic          dumping,
  output logic          done
);

  localparam int BPC = (SW + 7) / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int NB  = NCH * BPC;
  localparam int WW  = NCH * SW;

  localparam logic [7:0] HB2 = 8'(AW);
  localparam logic [7:0] HB3 = {4'(NCH), 2'(BPC), 2'b00};

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
`ifdef DUMP_HEADER_EN
    HDR,
`endif
    RD,
    LAT,
    SEND,
    ACK,
    DONE
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_addr_q;
  logic [AW-1:0]   rd_addr_q;
  logic [1:0]      byte_idx_q;
  logic [3:0][7:0] byte_buf_q;
  logic            hdr_q;
  logic            tx_start_q;
  logic [7:0]      tx_dat_q;
  logic            done_q;

  // Sample RAM: single write port, registered read (maps to SPRAM/BRAM)
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] wr_word;
  logic [WW-1:0] rd_word_q;
  logic          wr_en;

  generate
    if (NCH == 2) begin : g_two
      assign wr_word = {smp_q, smp_i};
    end else begin : g_one
      assign wr_word = smp_i;
    end
  endgenerate

  assign wr_en = (state_q == CAPTURE) && smp_stb;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= wr_word;
    rd_word_q <= mem[rd_addr_q];
  end

  // Split the read word into the transmit byte order: I then Q, LSB byte first, sign-extended
  logic signed [SW-1:0] chan_s;
  logic signed [15:0]   chan_ext;
  logic [3:0][7:0]      smp_bytes;

  always_comb begin
    smp_bytes = '0;
    chan_s    = '0;
    chan_ext  = '0;
    for (int c = 0; c < NCH; c++) begin
      chan_s   = rd_word_q[c*SW +: SW];
      chan_ext = 16'(chan_s);
      for (int b = 0; b < BPC; b++) smp_bytes[c*BPC + b] = chan_ext[b*8 +: 8];
    end
  end

  logic [1:0] last_idx;
  assign last_idx = hdr_q ? 2'd3 : 2'(NB - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      byte_idx_q <= '0;
      byte_buf_q <= '0;
      hdr_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_dat_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm || (AUTO_ARM != 0)) begin
            state_q   <= CAPTURE;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
          end
        end
        DONE: begin
          if (arm) begin
            state_q   <= CAPTURE;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
          end
        end
        CAPTURE: begin
          if (smp_stb) begin
            wr_addr_q <= wr_addr_q + AW'(1);
            if (wr_addr_q == AW'(DEPTH - 1)) begin
              rd_addr_q  <= '0;
              byte_idx_q <= '0;
`ifdef DUMP_HEADER_EN
              state_q    <= HDR;
`else
              state_q    <= RD;
`endif
            end
          end
        end
`ifdef DUMP_HEADER_EN
        HDR: begin
          byte_buf_q <= {HB3, HB2, 8'h5A, 8'hA5};
          hdr_q      <= 1'b1;
          byte_idx_q <= '0;
          state_q    <= SEND;
        end
`endif
        RD:  state_q <= LAT;
        LAT: begin
          byte_buf_q <= smp_bytes;
          hdr_q      <= 1'b0;
          state_q    <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_dat_q   <= byte_buf_q[byte_idx_q];
            state_q    <= ACK;
          end
        end
        ACK: begin
          // Guard cycle: the UART raises tx_busy in response to the pulse just issued
          if (byte_idx_q == last_idx) begin
            byte_idx_q <= '0;
            if (hdr_q) begin
              state_q <= RD;
            end else if (rd_addr_q == AW'(DEPTH - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              rd_addr_q <= rd_addr_q + AW'(1);
              state_q   <= RD;
            end
          end else begin
            byte_idx_q <= byte_idx_q + 2'd1;
            state_q    <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_dat    = tx_dat_q;
  assign done      = done_q;
  assign capturing = (state_q == CAPTURE);
`ifdef DUMP_HEADER_EN
  assign dumping   = (state_q == HDR) || (state_q == RD) || (state_q == LAT) ||
                     (state_q == SEND) || (state_q == ACK);
`else
  assign dumping   = (state_q == RD) || (state_q == LAT) ||
                     (state_q == SEND) || (state_q == ACK);
`endif

endmodule
